// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-memory multicycle datapath
// Handles memory-ready waits with a timeout, honours stall_in, and locks into FAULT on errors.
module multicycle_control #(
  parameter int OPW     = 7,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  input  logic           stall_in,
  output logic           pcwrite,
  output logic           irwrite,
  output logic           branch,
  output logic           memread,
  output logic           memwrite,
  output logic           memtoreg,
  output logic           alusrc,
  output logic           regwrite,
  output logic           jalnk,
  output logic           jalnr,
  output logic [1:0]     aluop,
  output logic           fault,
  output logic [2:0]     state
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;
  localparam logic [OPW-1:0] OP_R    = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_LW   = OPW'(7'b1100000);
  localparam logic [OPW-1:0] OP_SW   = OPW'(7'b1100010);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(7'b1101111);
  localparam logic [OPW-1:0] OP_JALR = OPW'(7'b1100111);
  state_t cs, ns;
  logic [OPW-1:0] op_q;
  logic [TO_W-1:0] cnt, cnt_n;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_jal, is_jalr, legal, to_hit;
  assign state   = cs;
  assign is_r    = op_q == OP_R;
  assign is_lw   = op_q == OP_LW;
  assign is_sw   = op_q == OP_SW;
  assign is_beq  = op_q == OP_BEQ;
  assign is_addi = op_q == OP_ADDI;
  assign is_jal  = op_q == OP_JAL;
  assign is_jalr = op_q == OP_JALR;
  assign legal   = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_JAL, OP_JALR};
  // cnt holds the number of wait cycles already spent; this cycle would be wait number cnt+1
  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
  always_comb begin
    ns       = cs;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    jalnk    = 1'b0;
    jalnr    = 1'b0;
    aluop    = 2'b00;
    fault    = cs == S_FAULT;
    case (cs)
      S_IDLE:   ns = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        ns      = mem_ready ? S_DECODE : to_hit ? S_FAULT : S_FETCH;
      end
      S_DECODE: ns = stall_in ? S_DECODE : legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        aluop    = (is_r || is_addi) ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        alusrc   = is_addi || is_lw || is_sw;
        branch   = is_beq || is_jalr;
        jalnk    = is_jal;
        jalnr    = is_jalr;
        regwrite = (is_jal || is_jalr) && !stall_in;
        pcwrite  = (is_jal || is_jalr) && !stall_in;
        ns       = stall_in ? S_EXEC : (is_lw || is_sw) ? S_MEM : (is_r || is_addi) ? S_WB : S_FETCH;
      end
      S_MEM: begin
        alusrc   = 1'b1;
        memread  = is_lw;
        memwrite = is_sw;
        ns       = mem_ready ? (is_lw ? S_WB : S_FETCH) : to_hit ? S_FAULT : S_MEM;
      end
      S_WB: begin
        regwrite = !stall_in;
        memtoreg = is_lw;
        ns       = stall_in ? S_WB : S_FETCH;
      end
      S_FAULT:  ns = S_FAULT;
      default:  ns = S_IDLE;
    endcase
  end
  assign cnt_n = (ns == cs && (cs == S_FETCH || cs == S_MEM) && !mem_ready && TIMEOUT != 0)
               ? ((&cnt) ? cnt : cnt + TO_W'(1)) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs   <= S_IDLE;
      op_q <= '0;
      cnt  <= '0;
    end else begin
      cs  <= ns;
      cnt <= cnt_n;
      if (cs == S_DECODE && !stall_in) op_q <= opcode;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vector table, corner sequences and a random instruction stream
// whose expected per-cycle trace is generated instruction by instruction from the control rules.
module tb_multicycle_control;
  logic clk = 1'b0, rst_n = 1'b0, rst0_n = 1'b0;
  logic mem_ready = 1'b0, stall_in = 1'b0, ready0 = 1'b0, stall0 = 1'b0;
  logic [6:0] opcode = '0;
  logic pcwrite, irwrite, branch, memread, memwrite, memtoreg, alusrc, regwrite, jalnk, jalnr, fault;
  logic [1:0] aluop;
  logic [2:0] state;
  logic pcwrite_z, irwrite_z, branch_z, memread_z, memwrite_z, memtoreg_z, alusrc_z, regwrite_z;
  logic jalnk_z, jalnr_z, fault_z;
  logic [1:0] aluop_z;
  logic [2:0] state_z;
  logic [15:0] obs, obs_z;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .stall_in(stall_in),
    .pcwrite(pcwrite), .irwrite(irwrite), .branch(branch), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .alusrc(alusrc), .regwrite(regwrite), .jalnk(jalnk), .jalnr(jalnr),
    .aluop(aluop), .fault(fault), .state(state)
  );

  multicycle_control #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .opcode(opcode), .mem_ready(ready0), .stall_in(stall0),
    .pcwrite(pcwrite_z), .irwrite(irwrite_z), .branch(branch_z), .memread(memread_z),
    .memwrite(memwrite_z), .memtoreg(memtoreg_z), .alusrc(alusrc_z), .regwrite(regwrite_z),
    .jalnk(jalnk_z), .jalnr(jalnr_z), .aluop(aluop_z), .fault(fault_z), .state(state_z)
  );

  assign obs   = {state, pcwrite, irwrite, branch, memread, memwrite, memtoreg, alusrc,
                  regwrite, jalnk, jalnr, aluop, fault};
  assign obs_z = {state_z, pcwrite_z, irwrite_z, branch_z, memread_z, memwrite_z, memtoreg_z,
                  alusrc_z, regwrite_z, jalnk_z, jalnr_z, aluop_z, fault_z};

  localparam logic [12:0] PCW = 13'h1000, IRW = 13'h0800, BR = 13'h0400, MR = 13'h0200;
  localparam logic [12:0] MW = 13'h0100, MTR = 13'h0080, ASRC = 13'h0040, RW = 13'h0020;
  localparam logic [12:0] JK = 13'h0010, JR = 13'h0008, AO10 = 13'h0004, AO01 = 13'h0002;
  localparam logic [12:0] FLT = 13'h0001, NONE = 13'h0000;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b1100000, OP_SW = 7'b1100010;
  localparam logic [6:0] OP_BEQ = 7'b1100011, OP_ADDI = 7'b0010011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        r;
    logic        s;
    logic [2:0]  st;
    logic [12:0] o;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got state=%0d ctl=%h, want state=%0d ctl=%h",
               nm, $time, got[15:13], got[12:0], want[15:13], want[12:0]);
    end
  endtask

  task automatic cyc(input logic [6:0] op, input logic r, input logic s,
                     input logic [2:0] st, input logic [12:0] o, input string nm);
    opcode = op;
    mem_ready = r;
    stall_in = s;
    @(negedge clk);
    check(nm, obs, {st, o});
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    stall_in = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle", obs, {ST_IDLE, NONE});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    stall_in = 1'b0;
    #1 check("reset", obs, 16'h0);
    release_rst();
  endtask

  task automatic v(input logic [6:0] op, input logic r, input logic s,
                   input logic [2:0] st, input logic [12:0] o);
    vec_t t;
    t.op = op; t.r = r; t.s = s; t.st = st; t.o = o;
    vq.push_back(t);
  endtask

  function automatic logic [12:0] exec_o(input logic [6:0] op, input logic stalled);
    logic [12:0] jw;
    jw = stalled ? NONE : (RW | PCW);
    case (op)
      OP_R:    return AO10;
      OP_ADDI: return AO10 | ASRC;
      OP_LW:   return ASRC;
      OP_SW:   return ASRC;
      OP_BEQ:  return AO01 | BR;
      OP_JAL:  return JK | jw;
      OP_JALR: return JR | BR | jw;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [12:0] mem_o(input logic [6:0] op);
    return ASRC | ((op == OP_LW) ? MR : MW);
  endfunction

  function automatic logic [12:0] wb_o(input logic [6:0] op, input logic stalled);
    return (stalled ? NONE : RW) | ((op == OP_LW) ? MTR : NONE);
  endfunction

  logic [6:0] ops [7];

  initial begin
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_JAL, OP_JALR};
    #12;
    check("reset at start", obs, 16'h0);
    release_rst();

    // rformat, lw with 3-cycle MEM wait, sw with ignored stall, beq, addi with stalls, jalr, jal stalled twice
    v(OP_R, 1, 0, ST_FETCH, MR | PCW | IRW);  v(OP_R, 1, 0, ST_DECODE, NONE);
    v(OP_R, 0, 0, ST_EXEC, AO10);             v(OP_R, 0, 0, ST_WB, RW);
    v(OP_LW, 1, 0, ST_FETCH, MR | PCW | IRW); v(OP_LW, 0, 0, ST_DECODE, NONE);
    v(OP_LW, 0, 0, ST_EXEC, ASRC);
    v(OP_LW, 0, 0, ST_MEM, ASRC | MR);        v(OP_LW, 0, 0, ST_MEM, ASRC | MR);
    v(OP_LW, 0, 0, ST_MEM, ASRC | MR);        v(OP_LW, 1, 0, ST_MEM, ASRC | MR);
    v(OP_LW, 0, 0, ST_WB, RW | MTR);
    v(OP_SW, 1, 0, ST_FETCH, MR | PCW | IRW); v(OP_SW, 0, 0, ST_DECODE, NONE);
    v(OP_SW, 0, 0, ST_EXEC, ASRC);            v(OP_SW, 1, 1, ST_MEM, ASRC | MW);
    v(OP_BEQ, 1, 1, ST_FETCH, MR | PCW | IRW); v(OP_BEQ, 0, 0, ST_DECODE, NONE);
    v(OP_BEQ, 0, 0, ST_EXEC, AO01 | BR);
    v(OP_ADDI, 1, 0, ST_FETCH, MR | PCW | IRW); v(OP_BAD, 1, 1, ST_DECODE, NONE);
    v(OP_ADDI, 0, 0, ST_DECODE, NONE);          v(OP_ADDI, 0, 1, ST_EXEC, AO10 | ASRC);
    v(7'h00, 0, 0, ST_EXEC, AO10 | ASRC);       v(OP_LW, 0, 1, ST_WB, NONE);
    v(OP_LW, 0, 0, ST_WB, RW);
    v(OP_JALR, 1, 0, ST_FETCH, MR | PCW | IRW); v(OP_JALR, 0, 0, ST_DECODE, NONE);
    v(OP_JALR, 0, 0, ST_EXEC, JR | BR | RW | PCW);
    v(OP_JAL, 1, 0, ST_FETCH, MR | PCW | IRW);  v(OP_JAL, 0, 0, ST_DECODE, NONE);
    v(OP_JAL, 0, 1, ST_EXEC, JK);               v(OP_JAL, 0, 1, ST_EXEC, JK);
    v(OP_JAL, 0, 0, ST_EXEC, JK | RW | PCW);
    v(OP_R, 0, 0, ST_FETCH, MR);
    foreach (vq[i]) cyc(vq[i].op, vq[i].r, vq[i].s, vq[i].st, vq[i].o, $sformatf("vec%0d", i));

    // async reset in the middle of a stalled jal
    do_reset();
    cyc(OP_JAL, 1, 0, ST_FETCH, MR | PCW | IRW, "jal fetch");
    cyc(OP_JAL, 0, 0, ST_DECODE, NONE, "jal decode");
    stall_in = 1'b1;
    #2 check("jal stalled", obs, {ST_EXEC, JK});
    rst_n = 1'b0;
    #1 check("async reset mid-stall", obs, 16'h0);
    release_rst();

    // illegal opcode traps and stays trapped
    cyc(OP_R, 1, 0, ST_FETCH, MR | PCW | IRW, "ill fetch");
    cyc(OP_BAD, 0, 0, ST_DECODE, NONE, "ill decode");
    for (int i = 0; i < 6; i++) cyc(7'($urandom), i[0], i[1], ST_FAULT, FLT, "fault sticky");

    // FETCH timeout after exactly 15 wait cycles
    do_reset();
    for (int i = 0; i < 15; i++) cyc(OP_R, 0, 0, ST_FETCH, MR, "fetch wait");
    cyc(OP_R, 1, 0, ST_FAULT, FLT, "fetch timeout");

    // 14 waits then ready: no fault; counter restarts for MEM
    do_reset();
    for (int i = 0; i < 14; i++) cyc(OP_LW, 0, 0, ST_FETCH, MR, "fetch wait14");
    cyc(OP_LW, 1, 0, ST_FETCH, MR | PCW | IRW, "fetch late ready");
    cyc(OP_LW, 0, 0, ST_DECODE, NONE, "lw decode");
    cyc(OP_LW, 0, 0, ST_EXEC, ASRC, "lw exec");
    for (int i = 0; i < 14; i++) cyc(OP_LW, 0, 0, ST_MEM, ASRC | MR, "mem wait14");
    cyc(OP_LW, 1, 0, ST_MEM, ASRC | MR, "mem late ready");
    cyc(OP_LW, 0, 0, ST_WB, RW | MTR, "lw wb");

    // MEM timeout on a store
    cyc(OP_SW, 1, 0, ST_FETCH, MR | PCW | IRW, "sw fetch");
    cyc(OP_SW, 0, 0, ST_DECODE, NONE, "sw decode");
    cyc(OP_SW, 0, 0, ST_EXEC, ASRC, "sw exec");
    for (int i = 0; i < 15; i++) cyc(OP_SW, 0, 0, ST_MEM, ASRC | MW, "sw mem wait");
    cyc(OP_SW, 0, 0, ST_FAULT, FLT, "mem timeout");

    // random instruction stream
    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      int w, s;
      op = ops[$urandom_range(0, 6)];
      w = $urandom_range(0, 6);
      for (int i = 0; i < w; i++) cyc(7'($urandom), 0, 1'($urandom), ST_FETCH, MR, "rnd fetch");
      cyc(7'($urandom), 1, 1'($urandom), ST_FETCH, MR | PCW | IRW, "rnd fetch rdy");
      s = $urandom_range(0, 2);
      for (int i = 0; i < s; i++) cyc(7'($urandom), 1'($urandom), 1, ST_DECODE, NONE, "rnd dec stall");
      cyc(op, 1'($urandom), 0, ST_DECODE, NONE, "rnd decode");
      s = $urandom_range(0, 2);
      for (int i = 0; i < s; i++) cyc(7'($urandom), 1'($urandom), 1, ST_EXEC, exec_o(op, 1), "rnd exec stall");
      cyc(7'($urandom), 1'($urandom), 0, ST_EXEC, exec_o(op, 0), "rnd exec");
      if (op == OP_LW || op == OP_SW) begin
        w = $urandom_range(0, 6);
        for (int i = 0; i < w; i++) cyc(7'($urandom), 0, 1'($urandom), ST_MEM, mem_o(op), "rnd mem wait");
        cyc(7'($urandom), 1, 1'($urandom), ST_MEM, mem_o(op), "rnd mem rdy");
      end
      if (op == OP_LW || op == OP_R || op == OP_ADDI) begin
        s = $urandom_range(0, 2);
        for (int i = 0; i < s; i++) cyc(7'($urandom), 1'($urandom), 1, ST_WB, wb_o(op, 1), "rnd wb stall");
        cyc(7'($urandom), 1'($urandom), 0, ST_WB, wb_o(op, 0), "rnd wb");
      end
    end

    // TIMEOUT=0 instance never faults in FETCH
    @(negedge clk);
    rst0_n = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("no timeout", obs_z, {ST_FETCH, MR});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle main control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the same datapath control set, plus PC/IR write enables.
- Waits on a memory-ready handshake with a parametrised timeout, honours an external stall, and traps illegal opcodes and memory timeouts into a sticky fault state.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- OPW, 7, opcode width. Opcode encodings are fixed team values, zero-extended if OPW > 7: rformat 0110011, lw 1100000, sw 1100010, beq 1100011, addi 0010011, jal 1101111, jalr 1100111.
- TIMEOUT, 15, maximum consecutive wait cycles for mem_ready before fault. 0 disables the timeout.
- TO_W, 4, wait-counter width. Must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPW  instruction opcode from the IR. Sampled in DECODE only.
- mem_ready  in  1  memory completes the current read or write this cycle
- stall_in  in  1  hold request; honoured in DECODE/EXEC/WB only
- pcwrite  out  1  PC update enable
- irwrite  out  1  IR load enable
- branch, memread, memwrite, memtoreg, alusrc, regwrite, jalnk, jalnr  out  1 each  datapath controls, same meaning as the single-cycle decoder
- aluop  out  2  00 add, 01 compare/sub, 10 funct-decoded
- fault  out  1  sticky error flag
- state  out  3  current state, for debug

Behaviour:
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- Reset (rst_n low, async):
  - state=IDLE; opcode register, wait counter and fault cleared.
  - Every output is 0, including aluop=00.
- Outputs never drive X. Every control not asserted in a state is 0.
- IDLE: all outputs 0; go to FETCH next cycle.
- FETCH:
  - memread=1.
  - If mem_ready=1: irwrite=1 and pcwrite=1 (combinational on mem_ready, same cycle); go to DECODE; clear counter.
  - Else: counter+1. When the counter reaches TIMEOUT with mem_ready still 0, go to FAULT.
- DECODE:
  - Latch opcode into an internal register; all outputs 0.
  - Illegal opcode: go to FAULT.
  - Otherwise go to EXEC.
- EXEC, driven from the latched opcode:
  - rformat: aluop=10, alusrc=0; go to WB.
  - addi: aluop=10, alusrc=1; go to WB.
  - lw/sw: aluop=00, alusrc=1; go to MEM.
  - beq: aluop=01, alusrc=0, branch=1; go to FETCH.
  - jal: jalnk=1, regwrite=1, pcwrite=1; go to FETCH.
  - jalr: jalnr=1, branch=1, regwrite=1, pcwrite=1, aluop=00; go to FETCH.
- MEM:
  - aluop=00, alusrc=1 held.
  - lw: memread=1. sw: memwrite=1.
  - Wait and timeout rules are identical to FETCH.
  - On mem_ready: lw goes to WB, sw goes to FETCH.
- WB:
  - regwrite=1 for one cycle; memtoreg=1 for lw, else 0.
  - Go to FETCH.
- stall_in=1 in DECODE/EXEC/WB:
  - State holds.
  - regwrite, pcwrite, irwrite, memwrite forced to 0; other controls keep their state values.
  - In DECODE the opcode is not latched while stalled.
  - stall_in is ignored in FETCH/MEM, where the memory handshake has priority.
- Counter rules:
  - Saturates; never wraps.
  - Cleared on every state change.
  - Unused when TIMEOUT=0.
- FAULT: fault=1, all other outputs 0. Exit only via rst_n.
- Reset mid-operation: async return to IDLE; a pending memory access is abandoned with no write enable asserted.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset release, then rformat with mem_ready=1 in FETCH:
  - State sequence 0,1,2,3,5,1.
  - regwrite=1 only in WB; memtoreg=0; aluop=10 in EXEC.
- lw with mem_ready delayed 3 cycles in MEM:
  - MEM lasts 4 cycles with memread=1.
  - WB has regwrite=1, memtoreg=1.
  - Then FETCH.
- sw then beq:
  - sw: memwrite=1 in MEM, never regwrite; returns to FETCH.
  - beq: EXEC shows branch=1, aluop=01; back to FETCH in 4 cycles from FETCH entry.
- Opcode 1111111 in DECODE:
  - Next state FAULT, fault=1, all else 0.
  - Stays there with mem_ready toggling until rst_n pulses low.
- TIMEOUT=15, mem_ready held 0 in FETCH:
  - FAULT entered exactly after the 15th wait cycle.
  - With TIMEOUT=0: FETCH persists for 100 cycles with no fault.
- jal with stall_in=1 for 2 cycles in EXEC:
  - EXEC held 3 cycles; pcwrite/regwrite 0 while stalled and 1 in the unstalled cycle; jalnk=1 throughout.
  - Asserting rst_n=0 mid-stall gives state=0 and all outputs 0 asynchronously.
